snake_move_ctrl: RTL and testbench

SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

---
 rtl/snake_move_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: moves the snake head across a GRID_W x GRID_H grid.
// One move happens every TICK_DIV clock cycles. The game has three states:
// IDLE, RUN and OVER.
//
// Ports:
//   clk        clock; all logic changes on the rising edge
//   reset      asynchronous, active-high reset
//   dir_in     one-hot direction request (0001 left, 0010 right, 0100 up, 1000 down)
//   start      starts or restarts a game from IDLE or OVER (sampled as a level)
//   head_x     head column; 0 is the left edge
//   head_y     head row; 0 is the top edge
//   cur_dir    direction currently applied (one-hot, or 0000 after reset)
//   step       one-cycle pulse on each completed head move
//   game_over  high while in OVER
//   score      completed steps in the current game; saturates at 255
//
// Build option: define SNAKE_WRAP_EN to make the head wrap to the opposite
// edge instead of ending the game.
module snake_move_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dir_in,
    input  logic       start,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [3:0] cur_dir,
    output logic       step,
    output logic       game_over,
    output logic [7:0] score
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
    localparam logic [5:0] Y_MAX = 6'(GRID_H - 1);
    localparam logic [5:0] X_MID = 6'(GRID_W / 2);
    localparam logic [5:0] Y_MID = 6'(GRID_H / 2);

    localparam logic [3:0] DIR_L = 4'b0001;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_D = 4'b1000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] tick;
    logic [3:0]       pending;
    logic             tick_done;
    logic [3:0]       dir_ref;
    logic [3:0]       dir_opp;
    logic             dir_ok;
    logic [5:0]       nx;
    logic [5:0]       ny;
    logic             off_grid;

    assign tick_done = (state == RUN) && (tick == TICK_LAST);
    assign game_over = (state == OVER);

    // On a step event, cur_dir takes the value of pending on the same edge.
    // A request arriving in that cycle is therefore checked against pending,
    // the direction that is about to become current.
    assign dir_ref = tick_done ? pending : cur_dir;
    assign dir_opp = {dir_ref[2], dir_ref[3], dir_ref[0], dir_ref[1]};

    always_comb begin
        dir_ok = 1'b0;
        case (dir_in)
            DIR_L, DIR_R, DIR_U, DIR_D: dir_ok = (dir_in != dir_opp);
            default:                    dir_ok = 1'b0;
        endcase
    end

    // Compute the candidate next head position from the pending direction.
    always_comb begin
        nx       = head_x;
        ny       = head_y;
        off_grid = 1'b0;
        case (pending)
            DIR_L: begin
                if (head_x == 6'd0) begin
`ifdef SNAKE_WRAP_EN
                    nx = X_MAX;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    nx = head_x - 6'd1;
                end
            end
            DIR_R: begin
                if (head_x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
                    nx = '0;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    nx = head_x + 6'd1;
                end
            end
            DIR_U: begin
                if (head_y == 6'd0) begin
`ifdef SNAKE_WRAP_EN
                    ny = Y_MAX;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    ny = head_y - 6'd1;
                end
            end
            DIR_D: begin
                if (head_y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
                    ny = '0;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    ny = head_y + 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            pending <= '0;
            cur_dir <= '0;
            head_x  <= '0;
            head_y  <= '0;
            score   <= '0;
            step    <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state   <= RUN;
                        tick    <= '0;
                        pending <= DIR_R;
                        cur_dir <= DIR_R;
                        head_x  <= X_MID;
                        head_y  <= Y_MID;
                        score   <= '0;
                    end
                end
                RUN: begin
                    if (dir_ok) begin
                        pending <= dir_in;
                    end
                    if (tick_done) begin
                        tick    <= '0;
                        cur_dir <= pending;
                        if (off_grid) begin
                            state <= OVER;
                        end else begin
                            head_x <= nx;
                            head_y <= ny;
                            step   <= 1'b1;
                            if (score != 8'hFF) begin
                                score <= score + 8'd1;
                            end
                        end
                    end else begin
                        tick <= tick + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
module tb_snake_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dir_in;
    logic       start;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [3:0] cur_dir;
    logic       step;
    logic       game_over;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        logic [3:0] d;
        logic [7:0] s;
        logic       go;
    } exp_t;

    exp_t sb[$];

    snake_move_ctrl #(
        .TICK_DIV (4),
        .GRID_W   (16),
        .GRID_H   (12)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dir_in    (dir_in),
        .start     (start),
        .head_x    (head_x),
        .head_y    (head_y),
        .cur_dir   (cur_dir),
        .step      (step),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int d, input int s, input bit go);
        exp_t e;
        e.x  = 6'(x);
        e.y  = 6'(y);
        e.d  = 4'(d);
        e.s  = 8'(s);
        e.go = go;
        sb.push_back(e);
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_step"}, step, !e.go);
            chk({tag, "_game_over"}, game_over, e.go);
            chk({tag, "_head_x"}, head_x, e.x);
            chk({tag, "_head_y"}, head_y, e.y);
            chk({tag, "_cur_dir"}, cur_dir, e.d);
            chk({tag, "_score"}, score, e.s);
        end
    endtask

    // Wait (bounded) for a step pulse or game_over, then score it.
    task automatic await_event(input string tag, output int cyc);
        bit hit = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (step || game_over) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s_timeout: observed=no event expected=event within 20 cycles", tag);
        end
        if (hit) compare_head(tag);
        else if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_head_x"}, head_x, 0);
        chk({tag, "_head_y"}, head_y, 0);
        chk({tag, "_cur_dir"}, cur_dir, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_score"}, score, 0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_head_x"}, head_x, 8);
        chk({tag, "_head_y"}, head_y, 6);
        chk({tag, "_cur_dir"}, cur_dir, 4'b0010);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_step"}, step, 0);
    endtask

    initial begin
        int  cyc;
        bit  saw;
        reset  = 1'b1;
        start  = 1'b0;
        dir_in = 4'b0000;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;
        @(negedge clk);

        // Start: centre of grid, moving right; first step 4 cycles into RUN.
        do_start("init");
        push(9, 6, 4'b0010, 1, 1'b0);
        await_event("first_step", cyc);
        chk("first_step_latency", cyc, 4);

        // Opposite request held two cycles is ignored.
        dir_in = 4'b0001;
        repeat (2) @(negedge clk);
        dir_in = 4'b0000;
        push(10, 6, 4'b0010, 2, 1'b0);
        await_event("opposite_ignored", cyc);

        // Up is latched, the later non-one-hot request is ignored.
        dir_in = 4'b0100;
        @(negedge clk);
        dir_in = 4'b0011;
        @(negedge clk);
        dir_in = 4'b0000;
        push(10, 5, 4'b0100, 3, 1'b0);
        await_event("turn_up", cyc);

        // Request in the step-event cycle applies only to the following step.
        repeat (3) @(negedge clk);
        dir_in = 4'b0010;
        push(10, 4, 4'b0100, 4, 1'b0);
        @(negedge clk);
        dir_in = 4'b0000;
        compare_head("same_cycle_req");
        push(11, 4, 4'b0010, 5, 1'b0);
        await_event("same_cycle_next", cyc);

        // start is ignored while running.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push(12, 4, 4'b0010, 6, 1'b0);
        await_event("start_in_run", cyc);

        // Reset mid-count (tick counter at 2), then idle until start.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (step) saw = 1'b1;
        end
        chk("idle_no_step", saw, 0);
        chk("idle_head_x", head_x, 0);
        chk("idle_cur_dir", cur_dir, 0);
        do_start("restart");

        // Run right into the right edge.
        for (int i = 1; i <= 7; i++) push(8 + i, 6, 4'b0010, i, 1'b0);
`ifdef SNAKE_WRAP_EN
        push(0, 6, 4'b0010, 8, 1'b0);
`else
        push(15, 6, 4'b0010, 7, 1'b1);
`endif
        for (int i = 0; i < 8; i++) await_event("run_right", cyc);
`ifdef SNAKE_WRAP_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`else
        repeat (5) @(negedge clk);
        chk("over_hold_x", head_x, 15);
        chk("over_hold_score", score, 7);
        chk("over_hold_go", game_over, 1);
        chk("over_hold_step", step, 0);
        chk("over_hold_dir", cur_dir, 4'b0010);
`endif
        do_start("restart_over");

        // Run up into the top edge.
        dir_in = 4'b0100;
        @(negedge clk);
        dir_in = 4'b0000;
        for (int i = 1; i <= 6; i++) push(8, 6 - i, 4'b0100, i, 1'b0);
`ifdef SNAKE_WRAP_EN
        push(8, 11, 4'b0100, 7, 1'b0);
`else
        push(8, 0, 4'b0100, 6, 1'b1);
`endif
        for (int i = 0; i < 7; i++) await_event("run_up", cyc);
`ifdef SNAKE_WRAP_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        do_start("restart_top");

        // Down then left.
        dir_in = 4'b1000;
        @(negedge clk);
        dir_in = 4'b0000;
        push(8, 7, 4'b1000, 1, 1'b0);
        await_event("turn_down", cyc);
        dir_in = 4'b0001;
        @(negedge clk);
        dir_in = 4'b0000;
        push(7, 7, 4'b0001, 2, 1'b0);
        await_event("turn_left", cyc);

`ifdef SNAKE_WRAP_EN
        // Long run: score saturates at 255.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_start("restart_long");
        for (int i = 1; i <= 260; i++)
            push((8 + i) % 16, 6, 4'b0010, (i > 255) ? 255 : i, 1'b0);
        for (int i = 0; i < 260; i++) await_event("long_run", cyc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_start("restart_after_long");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
